// File: rtl/settings_bus_sequencer_if.sv
// Command stream, settings-bus, readback and response signals of settings_bus_sequencer.
// master = the sequencer itself, slave = host/daughterboard side.
interface settings_bus_sequencer_if;
  logic [47:0] cmd_tdata;
  logic        cmd_tuser;
  logic        cmd_tvalid;
  logic        cmd_tready;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [7:0]  rb_addr;
  logic        rb_stb;
  logic [63:0] rb_data;
  logic [63:0] resp_tdata;
  logic        resp_tuser;
  logic        resp_tvalid;
  logic        resp_tready;

  modport master (
    input  cmd_tdata, cmd_tuser, cmd_tvalid, rb_stb, rb_data, resp_tready,
    output cmd_tready, set_stb, set_addr, set_data, rb_addr,
           resp_tdata, resp_tuser, resp_tvalid
  );

  modport slave (
    output cmd_tdata, cmd_tuser, cmd_tvalid, rb_stb, rb_data, resp_tready,
    input  cmd_tready, set_stb, set_addr, set_data, rb_addr,
           resp_tdata, resp_tuser, resp_tvalid
  );
endinterface

// File: rtl/settings_bus_sequencer.sv
// Serialises host commands onto the settings bus and returns readback words.
// Optional readback timeout enabled by defining SETTINGS_SEQ_TIMEOUT_EN.
module settings_bus_sequencer #(
  parameter int unsigned SETTLE_CYC = 2
`ifdef SETTINGS_SEQ_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 65535
  , parameter logic [63:0] ERR_WORD    = 64'h0BADC0DE_DEADBEEF
`endif
) (
  input  logic                         clk,
  input  logic                         reset_n,
  settings_bus_sequencer_if.master     bus
);

  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE,
    S_SETTLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic             cmd_tready_q, cmd_tready_d;
  logic             set_stb_q, set_stb_d;
  logic [7:0]       set_addr_q, set_addr_d;
  logic [31:0]      set_data_q, set_data_d;
  logic [7:0]       rb_addr_q, rb_addr_d;
  logic             rd_req_q, rd_req_d;
  logic [SET_W-1:0] settle_cnt_q, settle_cnt_d;
  logic             resp_tvalid_q, resp_tvalid_d;
  logic [63:0]      resp_tdata_q, resp_tdata_d;
`ifdef SETTINGS_SEQ_TIMEOUT_EN
  localparam logic [16:0] WAIT_LAST = 17'(TIMEOUT_CYC - 1);
  logic             resp_tuser_q, resp_tuser_d;
  logic [16:0]      wait_cnt_q, wait_cnt_d;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    set_stb_d     = 1'b0;
    set_addr_d    = set_addr_q;
    set_data_d    = set_data_q;
    rb_addr_d     = rb_addr_q;
    rd_req_d      = rd_req_q;
    settle_cnt_d  = settle_cnt_q;
    resp_tvalid_d = resp_tvalid_q;
    resp_tdata_d  = resp_tdata_q;
`ifdef SETTINGS_SEQ_TIMEOUT_EN
    resp_tuser_d  = resp_tuser_q;
    wait_cnt_d    = wait_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_tvalid && cmd_tready_q) begin
          set_addr_d = bus.cmd_tdata[47:40];
          rb_addr_d  = bus.cmd_tdata[39:32];
          set_data_d = bus.cmd_tdata[31:0];
          rd_req_d   = bus.cmd_tuser;
          set_stb_d  = 1'b1;
          state_d    = S_STROBE;
        end
      end
      S_STROBE: begin
        settle_cnt_d = '0;
        state_d      = rd_req_q ? S_SETTLE : S_IDLE;
      end
      // rb_stb may still be high from before the trigger write; ignore it here
      S_SETTLE: begin
        if (settle_cnt_q == SET_LAST) begin
          state_d = S_WAIT;
`ifdef SETTINGS_SEQ_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      S_WAIT: begin
        if (bus.rb_stb) begin
          resp_tdata_d  = bus.rb_data;
          resp_tvalid_d = 1'b1;
          state_d       = S_RESP;
`ifdef SETTINGS_SEQ_TIMEOUT_EN
          resp_tuser_d  = 1'b0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          resp_tdata_d  = ERR_WORD;
          resp_tuser_d  = 1'b1;
          resp_tvalid_d = 1'b1;
          state_d       = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 17'd1;
`endif
        end
      end
      S_RESP: begin
        if (bus.resp_tready) begin
          resp_tvalid_d = 1'b0;
          state_d       = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_tready_d = (state_d == S_IDLE);
  end

  // Reset clears cmd_tready, so acceptance starts one cycle after release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cmd_tready_q  <= 1'b0;
      set_stb_q     <= 1'b0;
      set_addr_q    <= '0;
      set_data_q    <= '0;
      rb_addr_q     <= '0;
      rd_req_q      <= 1'b0;
      settle_cnt_q  <= '0;
      resp_tvalid_q <= 1'b0;
      resp_tdata_q  <= '0;
`ifdef SETTINGS_SEQ_TIMEOUT_EN
      resp_tuser_q  <= 1'b0;
      wait_cnt_q    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      cmd_tready_q  <= cmd_tready_d;
      set_stb_q     <= set_stb_d;
      set_addr_q    <= set_addr_d;
      set_data_q    <= set_data_d;
      rb_addr_q     <= rb_addr_d;
      rd_req_q      <= rd_req_d;
      settle_cnt_q  <= settle_cnt_d;
      resp_tvalid_q <= resp_tvalid_d;
      resp_tdata_q  <= resp_tdata_d;
`ifdef SETTINGS_SEQ_TIMEOUT_EN
      resp_tuser_q  <= resp_tuser_d;
      wait_cnt_q    <= wait_cnt_d;
`endif
    end
  end

  assign bus.cmd_tready  = cmd_tready_q;
  assign bus.set_stb     = set_stb_q;
  assign bus.set_addr    = set_addr_q;
  assign bus.set_data    = set_data_q;
  assign bus.rb_addr     = rb_addr_q;
  assign bus.resp_tvalid = resp_tvalid_q;
  assign bus.resp_tdata  = resp_tdata_q;
`ifdef SETTINGS_SEQ_TIMEOUT_EN
  assign bus.resp_tuser  = resp_tuser_q;
`else
  assign bus.resp_tuser  = 1'b0;
`endif

endmodule

// File: tb/tb_settings_bus_sequencer.sv
// Randomised bench for settings_bus_sequencer; expected timing and data come from
// per-command rb_stb/rb_data patterns scanned against the settle/timeout windows.
module tb_settings_bus_sequencer;
  localparam int unsigned S    = 3;
  localparam int unsigned MAXK = 256;
  localparam logic [63:0] ERR  = 64'h0BADC0DE_DEADBEEF;
`ifdef SETTINGS_SEQ_TIMEOUT_EN
  localparam int unsigned T = 100;
`else
  localparam int unsigned T = 100000;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  always #5 clk = ~clk;

  settings_bus_sequencer_if bus();

`ifdef SETTINGS_SEQ_TIMEOUT_EN
  settings_bus_sequencer #(.SETTLE_CYC(S), .TIMEOUT_CYC(T), .ERR_WORD(ERR)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
`else
  settings_bus_sequencer #(.SETTLE_CYC(S)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));
`endif

  // One command: r = first interval (after the strobe interval 0) where rb_stb returns high,
  // b = cycles of response backpressure, glitch = random rb_stb activity while settling.
  task automatic run_cmd(input logic tuser, input logic [7:0] a, input logic [7:0] rba,
                         input logic [31:0] d, input int unsigned r, input int unsigned b,
                         input bit glitch, input bit use_fixed, input logic [63:0] fixed_d);
    bit          stb_pat [MAXK];
    logic [63:0] dat_pat [MAXK];
    int unsigned c;
    bit          to;
    logic [63:0] exp_d;
    int unsigned w;
    for (int k = 0; k < MAXK; k++) begin
      stb_pat[k] = (k == 0) || (k >= r) || (glitch && k <= S && $urandom_range(0, 1) == 1);
      dat_pat[k] = use_fixed ? fixed_d : {$urandom, $urandom};
    end
    c = S + 1;
    while (!stb_pat[c] && c < S + T) c++;
    to    = !stb_pat[c];
    exp_d = to ? ERR : dat_pat[c];

    w = 0;
    while (bus.cmd_tready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    n_chk++;
    if (bus.cmd_tready !== 1'b1) $display("FAIL cmd_ready_wait: got %b required 1", bus.cmd_tready);
    else n_pass++;

    bus.cmd_tdata  = {a, rba, d};
    bus.cmd_tuser  = tuser;
    bus.cmd_tvalid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_tvalid = 1'b0;
    bus.cmd_tdata  = {$urandom, $urandom};
    bus.cmd_tuser  = 1'b0;

    if (!tuser) begin
      bus.rb_stb = 1'b1; bus.rb_data = dat_pat[0];
      @(negedge clk);
      n_chk++;
      if (bus.set_stb !== 1'b1 || bus.set_addr !== a || bus.set_data !== d || bus.rb_addr !== rba)
        $display("FAIL wr_strobe: got stb=%b addr=%h data=%h rb=%h required 1 %h %h %h",
                 bus.set_stb, bus.set_addr, bus.set_data, bus.rb_addr, a, d, rba);
      else n_pass++;
      n_chk++;
      if (bus.cmd_tready !== 1'b0 || bus.resp_tvalid !== 1'b0)
        $display("FAIL wr_busy: got ready=%b tvalid=%b required 0 0", bus.cmd_tready, bus.resp_tvalid);
      else n_pass++;
      @(posedge clk); #1;
      @(negedge clk);
      n_chk++;
      if (bus.set_stb !== 1'b0 || bus.cmd_tready !== 1'b1 || bus.resp_tvalid !== 1'b0)
        $display("FAIL wr_done: got stb=%b ready=%b tvalid=%b required 0 1 0",
                 bus.set_stb, bus.cmd_tready, bus.resp_tvalid);
      else n_pass++;
      n_chk++;
      if (bus.set_addr !== a || bus.set_data !== d)
        $display("FAIL wr_hold: got %h/%h required %h/%h", bus.set_addr, bus.set_data, a, d);
      else n_pass++;
      return;
    end

    for (int unsigned k = 0; k <= c; k++) begin
      bus.rb_stb      = stb_pat[k];
      bus.rb_data     = dat_pat[k];
      bus.resp_tready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_chk++;
      if (bus.set_stb !== (k == 0) || bus.cmd_tready !== 1'b0 || bus.resp_tvalid !== 1'b0)
        $display("FAIL rd_pending k=%0d: got stb=%b ready=%b tvalid=%b required %b 0 0",
                 k, bus.set_stb, bus.cmd_tready, bus.resp_tvalid, (k == 0));
      else n_pass++;
      n_chk++;
      if (bus.rb_addr !== rba || bus.set_addr !== a || bus.set_data !== d)
        $display("FAIL rd_addr k=%0d: got rb=%h addr=%h data=%h required %h %h %h",
                 k, bus.rb_addr, bus.set_addr, bus.set_data, rba, a, d);
      else n_pass++;
      @(posedge clk); #1;
    end

    for (int unsigned i = 0; i <= b; i++) begin
      bus.rb_stb      = 1'($urandom_range(0, 1));
      bus.rb_data     = {$urandom, $urandom};
      bus.resp_tready = (i == b);
      @(negedge clk);
      n_chk++;
      if (bus.resp_tvalid !== 1'b1 || bus.resp_tdata !== exp_d || bus.resp_tuser !== to)
        $display("FAIL rd_resp i=%0d: got v=%b data=%h user=%b required 1 %h %b",
                 i, bus.resp_tvalid, bus.resp_tdata, bus.resp_tuser, exp_d, to);
      else n_pass++;
      n_chk++;
      if (bus.cmd_tready !== 1'b0)
        $display("FAIL rd_resp_ready i=%0d: got %b required 0", i, bus.cmd_tready);
      else n_pass++;
      @(posedge clk); #1;
    end
    bus.resp_tready = 1'b0;
    bus.rb_stb      = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.resp_tvalid !== 1'b0 || bus.cmd_tready !== 1'b1 || bus.set_stb !== 1'b0)
      $display("FAIL rd_done: got tvalid=%b ready=%b stb=%b required 0 1 0",
               bus.resp_tvalid, bus.cmd_tready, bus.set_stb);
    else n_pass++;
    n_chk++;
    if (bus.set_addr !== a || bus.set_data !== d || bus.rb_addr !== rba)
      $display("FAIL rd_hold: got %h %h %h required %h %h %h",
               bus.set_addr, bus.set_data, bus.rb_addr, a, d, rba);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_chk++;
    if (bus.cmd_tready !== 1'b0 || bus.set_stb !== 1'b0 || bus.resp_tvalid !== 1'b0 ||
        bus.resp_tuser !== 1'b0)
      $display("FAIL reset_ctrl: got ready=%b stb=%b tvalid=%b tuser=%b required 0 0 0 0",
               bus.cmd_tready, bus.set_stb, bus.resp_tvalid, bus.resp_tuser);
    else n_pass++;
    n_chk++;
    if (bus.set_addr !== 8'h00 || bus.set_data !== 32'h0 || bus.rb_addr !== 8'h00 ||
        bus.resp_tdata !== 64'h0)
      $display("FAIL reset_data: got %h %h %h %h required zeros",
               bus.set_addr, bus.set_data, bus.rb_addr, bus.resp_tdata);
    else n_pass++;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.cmd_tready !== 1'b0) $display("FAIL reset_first_cycle_ready: got %b required 0", bus.cmd_tready);
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (bus.cmd_tready !== 1'b1) $display("FAIL reset_ready_up: got %b required 1", bus.cmd_tready);
    else n_pass++;
  endtask

  task automatic test_write_only();
    run_cmd(1'b0, 8'hA0, 8'h00, 32'h1234_5678, 0, 0, 1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 10; i++)
      run_cmd(1'b0, 8'($urandom), 8'($urandom), $urandom, 0, 0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_readback_held();
    run_cmd(1'b1, 8'h10, 8'h22, 32'h0000_00FF, 0, 0, 1'b0, 1'b1, 64'h1111_2222_3333_4444);
  endtask

  task automatic test_spi_wait();
    run_cmd(1'b1, 8'h20, 8'h05, 32'h8000_0001, 41, 0, 1'b0, 1'b1, 64'hAB);
  endtask

  task automatic test_backpressure();
    run_cmd(1'b1, 8'h30, 8'h07, $urandom, 2, 10, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_random_mix();
    for (int i = 0; i < 30; i++)
      run_cmd(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), $urandom,
              $urandom_range(0, 60), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
              1'b0, 64'h0);
  endtask

`ifdef SETTINGS_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    run_cmd(1'b1, 8'h40, 8'h09, 32'h0, MAXK, 1, 1'b0, 1'b0, 64'h0);
    run_cmd(1'b1, 8'h41, 8'h09, 32'h1, S + T, 0, 1'b0, 1'b0, 64'h0);
    run_cmd(1'b1, 8'h42, 8'h09, 32'h2, S + T + 1, 0, 1'b0, 1'b0, 64'h0);
  endtask
`endif

  // Reset asserted at interval at_k of a readback that never completes
  task automatic test_reset_abort(input int unsigned at_k);
    int unsigned w;
    w = 0;
    while (bus.cmd_tready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    bus.cmd_tdata  = {8'h55, 8'h66, 32'hCAFE_F00D};
    bus.cmd_tuser  = 1'b1;
    bus.cmd_tvalid = 1'b1;
    @(posedge clk); #1;
    bus.cmd_tvalid = 1'b0;
    bus.rb_stb     = 1'b0;
    for (int unsigned k = 0; k < at_k; k++) begin
      @(posedge clk); #1;
    end
    if (at_k == 0) begin
      n_chk++;
      if (bus.set_stb !== 1'b1) $display("FAIL abort_pre_stb: got %b required 1", bus.set_stb);
      else n_pass++;
    end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (bus.set_stb !== 1'b0 || bus.resp_tvalid !== 1'b0 || bus.cmd_tready !== 1'b0 ||
        bus.set_addr !== 8'h00)
      $display("FAIL abort_k%0d: got stb=%b tvalid=%b ready=%b addr=%h required 0 0 0 00",
               at_k, bus.set_stb, bus.resp_tvalid, bus.cmd_tready, bus.set_addr);
    else n_pass++;
    @(posedge clk); #1;
    reset_n    = 1'b1;
    bus.rb_stb = 1'b1;
    run_cmd(1'b0, 8'hA0, 8'h00, 32'h1234_5678, 0, 0, 1'b0, 1'b0, 64'h0);
  endtask

  initial begin
    bus.cmd_tdata   = '0;
    bus.cmd_tuser   = 1'b0;
    bus.cmd_tvalid  = 1'b0;
    bus.rb_stb      = 1'b1;
    bus.rb_data     = '0;
    bus.resp_tready = 1'b0;
    test_reset();
    test_write_only();
    test_readback_held();
    test_spi_wait();
    test_backpressure();
    test_random_mix();
`ifdef SETTINGS_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_abort(S + 5);
    test_reset_abort(0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
